// File: rtl/rv32i_dmem_arbiter.sv
// Two-port arbiter/sequencer in front of rv32i_data_mem: port 0 (MEM stage) has priority, port 1 (debug/loader) is anti-starved.
// Optional misalignment rejection is enabled by defining DMEM_ARB_MISALIGN_CHK_EN.
module rv32i_dmem_arbiter #(
   parameter int WIDTH        = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_p0_req,
   input  logic                  i_p0_we,
   input  logic [ADDR_WIDTH-1:0] i_p0_addr,
   input  logic [WIDTH-1:0]      i_p0_wdata,
   input  logic [2:0]            i_p0_func3,
   input  logic                  i_p1_req,
   input  logic                  i_p1_we,
   input  logic [ADDR_WIDTH-1:0] i_p1_addr,
   input  logic [WIDTH-1:0]      i_p1_wdata,
   input  logic [2:0]            i_p1_func3,
   output logic                  o_p0_gnt,
   output logic                  o_p0_rvalid,
   output logic [WIDTH-1:0]      o_p0_rdata,
   output logic                  o_p0_err,
   output logic                  o_p1_gnt,
   output logic                  o_p1_rvalid,
   output logic [WIDTH-1:0]      o_p1_rdata,
   output logic                  o_p1_err,
   output logic                  o_dm_we,
   output logic [ADDR_WIDTH-1:0] o_dm_addr,
   output logic [WIDTH-1:0]      o_dm_data_in,
   output logic [2:0]            o_dm_func3,
   input  logic [WIDTH-1:0]      i_dm_data_out
);

   typedef enum logic [1:0] {IDLE, RESP0, RESP1} state_t;

   state_t                state, state_next;
   logic [3:0]            starve_cnt;
   logic                  gnt0, gnt1, any_gnt;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [WIDTH-1:0]      sel_wdata;
   logic [2:0]            sel_func3;
   logic                  misaligned;
   logic [WIDTH-1:0]      resp_val;
   logic [WIDTH-1:0]      rdata0, rdata1;
   logic                  err0, err1;

   // Port 1 only overrides port 0 once it has been starved for STARVE_LIMIT cycles
   always_comb begin
      gnt1      = i_p1_req && (!i_p0_req || (starve_cnt == 4'(STARVE_LIMIT)));
      gnt0      = i_p0_req && !gnt1;
      any_gnt   = gnt0 || gnt1;
      sel_we    = gnt1 ? i_p1_we    : i_p0_we;
      sel_addr  = gnt1 ? i_p1_addr  : i_p0_addr;
      sel_wdata = gnt1 ? i_p1_wdata : i_p0_wdata;
      sel_func3 = gnt1 ? i_p1_func3 : i_p0_func3;
   end

`ifdef DMEM_ARB_MISALIGN_CHK_EN
   assign misaligned = ((sel_func3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00)) ||
                       ((sel_func3[1:0] == 2'b01) && sel_addr[0]);
`else
   assign misaligned = 1'b0;
`endif

   assign resp_val     = (misaligned || sel_we) ? '0 : i_dm_data_out;
   assign o_dm_we      = rst_n && any_gnt && sel_we && !misaligned;
   assign o_dm_addr    = sel_addr;
   assign o_dm_data_in = sel_wdata;
   assign o_dm_func3   = sel_func3;
   assign o_p0_gnt     = gnt0;
   assign o_p1_gnt     = gnt1;
   assign o_p0_rdata   = rdata0;
   assign o_p1_rdata   = rdata1;
   assign o_p0_err     = err0;
   assign o_p1_err     = err1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         rdata0     <= '0;
         rdata1     <= '0;
         err0       <= 1'b0;
         err1       <= 1'b0;
      end else begin
         state <= state_next;
         if (!i_p1_req || gnt1)
            starve_cnt <= 4'd0;
         else if (starve_cnt != 4'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 4'd1;
         if (gnt0) begin
            rdata0 <= resp_val;
            err0   <= misaligned;
         end
         if (gnt1) begin
            rdata1 <= resp_val;
            err1   <= misaligned;
         end
      end
   end

   always_comb begin
      state_next  = IDLE;
      o_p0_rvalid = (state == RESP0);
      o_p1_rvalid = (state == RESP1);
      if (gnt0)
         state_next = RESP0;
      else if (gnt1)
         state_next = RESP1;
   end

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Directed bench for rv32i_dmem_arbiter with a behavioural byte-addressed data memory.
module tb_rv32i_dmem_arbiter;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
   logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
   logic [2:0]  p0_func3 = 0, p1_func3 = 0;
   logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic        dm_we;
   logic [31:0] dm_addr, dm_data_in, dm_data_out;
   logic [2:0]  dm_func3;
   logic [7:0]  mem [0:255];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   rv32i_dmem_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_func3(p0_func3),
      .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_func3(p1_func3),
      .o_p0_gnt(p0_gnt), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata), .o_p0_err(p0_err),
      .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata), .o_p1_err(p1_err),
      .o_dm_we(dm_we), .o_dm_addr(dm_addr), .o_dm_data_in(dm_data_in), .o_dm_func3(dm_func3),
      .i_dm_data_out(dm_data_out)
   );

   // Little-endian memory with a combinational, func3-extended read
   always_comb begin
      logic [7:0] a;
      logic [7:0] b0, b1, b2, b3;
      a  = dm_addr[7:0];
      b0 = mem[a];
      b1 = mem[a + 8'd1];
      b2 = mem[a + 8'd2];
      b3 = mem[a + 8'd3];
      dm_data_out = 32'd0;
      case (dm_func3)
         3'b000:  dm_data_out = {{24{b0[7]}}, b0};
         3'b001:  dm_data_out = {{16{b1[7]}}, b1, b0};
         3'b010:  dm_data_out = {b3, b2, b1, b0};
         3'b100:  dm_data_out = {24'd0, b0};
         3'b101:  dm_data_out = {16'd0, b1, b0};
         default: dm_data_out = 32'd0;
      endcase
   end

   always @(posedge clk) begin
      if (dm_we) begin
         mem[dm_addr[7:0]] <= dm_data_in[7:0];
         if (dm_func3[1:0] != 2'b00) mem[dm_addr[7:0] + 8'd1] <= dm_data_in[15:8];
         if (dm_func3[1:0] == 2'b10) begin
            mem[dm_addr[7:0] + 8'd2] <= dm_data_in[23:16];
            mem[dm_addr[7:0] + 8'd3] <= dm_data_in[31:24];
         end
      end
   end

   task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] func3);
      if (port == 0) begin
         p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_func3 = func3;
      end else begin
         p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_func3 = func3;
      end
   endtask

   task automatic clearRequests();
      p0_req = 1'b0;
      p1_req = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      // Reset state, with a pending store that must not reach memory
      #2;
      applyStimulus(0, 1'b1, 32'd0, 32'hDEADBEEF, 3'b010);
      #1;
      checkOutput("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
      checkOutput("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
      checkOutput("rst_p0_rdata", p0_rdata, 32'd0);
      checkOutput("rst_p1_err", {31'd0, p1_err}, 32'd0);
      checkOutput("rst_dm_we", {31'd0, dm_we}, 32'd0);
      clearRequests();
      tick();
      rst_n = 1'b1;

      // Port 0 SW then LW at address 0
      applyStimulus(0, 1'b1, 32'd0, 32'hDEADBEEF, 3'b010);
      #1;
      checkOutput("p0_sw_gnt", {31'd0, p0_gnt}, 32'd1);
      checkOutput("p0_sw_dm_we", {31'd0, dm_we}, 32'd1);
      checkOutput("p0_sw_p1_gnt", {31'd0, p1_gnt}, 32'd0);
      tick();
      checkOutput("p0_sw_rvalid", {31'd0, p0_rvalid}, 32'd1);
      checkOutput("p0_sw_rdata", p0_rdata, 32'd0);
      applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'b010);
      #1;
      checkOutput("p0_lw_gnt", {31'd0, p0_gnt}, 32'd1);
      tick();
      checkOutput("p0_lw_rvalid", {31'd0, p0_rvalid}, 32'd1);
      checkOutput("p0_lw_rdata", p0_rdata, 32'hDEADBEEF);
      clearRequests();
      tick();
      checkOutput("p0_idle_rvalid", {31'd0, p0_rvalid}, 32'd0);

      // Port 1 alone: byte stores and sign/zero-extended byte loads
      applyStimulus(1, 1'b1, 32'd8, 32'hDEADBEEF, 3'b000);
      #1;
      checkOutput("p1_sb_gnt", {31'd0, p1_gnt}, 32'd1);
      tick();
      checkOutput("p1_sb_rvalid", {31'd0, p1_rvalid}, 32'd1);
      checkOutput("p1_sb_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
      applyStimulus(1, 1'b0, 32'd8, 32'd0, 3'b100);
      tick();
      checkOutput("p1_lbu_rdata", p1_rdata, 32'h000000EF);
      applyStimulus(1, 1'b1, 32'd8, 32'h00000080, 3'b000);
      tick();
      applyStimulus(1, 1'b0, 32'd8, 32'd0, 3'b000);
      tick();
      checkOutput("p1_lb_rdata", p1_rdata, 32'hFFFFFF80);
      clearRequests();
      tick();

      // Back-to-back SW then LH on port 0
      applyStimulus(0, 1'b1, 32'd12, 32'hFFFFFFFB, 3'b010);
      tick();
      checkOutput("b2b_sw_rvalid", {31'd0, p0_rvalid}, 32'd1);
      applyStimulus(0, 1'b0, 32'd12, 32'd0, 3'b001);
      tick();
      checkOutput("b2b_lh_rvalid", {31'd0, p0_rvalid}, 32'd1);
      checkOutput("b2b_lh_rdata", p0_rdata, 32'hFFFFFFFB);
      clearRequests();
      tick();

      // Both ports request continuously: port 1 wins every fifth cycle
      applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'b010);
      applyStimulus(1, 1'b0, 32'd8, 32'd0, 3'b010);
      for (int i = 0; i < 10; i++) begin
         #1;
         checkOutput($sformatf("starve_p1_gnt_%0d", i), {31'd0, p1_gnt}, {31'd0, (i % 5) == 4});
         checkOutput($sformatf("starve_p0_gnt_%0d", i), {31'd0, p0_gnt}, {31'd0, (i % 5) != 4});
         tick();
         checkOutput($sformatf("starve_p1_rvalid_%0d", i), {31'd0, p1_rvalid}, {31'd0, (i % 5) == 4});
         if ((i % 5) == 4)
            checkOutput($sformatf("starve_p1_rdata_%0d", i), p1_rdata, 32'h00000080);
         else
            checkOutput($sformatf("starve_p0_rdata_%0d", i), p0_rdata, 32'hDEADBEEF);
      end
      clearRequests();
      tick();

      // Misaligned word store at address 2
      applyStimulus(0, 1'b1, 32'd2, 32'h11223344, 3'b010);
      #1;
      checkOutput("mis_dm_we", {31'd0, dm_we}, {31'd0, !MIS_EN});
      tick();
      checkOutput("mis_rvalid", {31'd0, p0_rvalid}, 32'd1);
      checkOutput("mis_err", {31'd0, p0_err}, {31'd0, MIS_EN});

      // Asynchronous reset between edges, with a store pending
      applyStimulus(0, 1'b1, 32'd16, 32'h00000055, 3'b010);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
      checkOutput("arst_p0_err", {31'd0, p0_err}, 32'd0);
      checkOutput("arst_dm_we", {31'd0, dm_we}, 32'd0);
      checkOutput("arst_p0_rdata", p0_rdata, 32'd0);
      tick();
      rst_n = 1'b1;
      applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'b010);
      #1;
      checkOutput("post_rst_gnt", {31'd0, p0_gnt}, 32'd1);
      tick();
      checkOutput("post_rst_rvalid", {31'd0, p0_rvalid}, 32'd1);
      checkOutput("post_rst_lw_rdata", p0_rdata, MIS_EN ? 32'hDEADBEEF : 32'h3344BEEF);
      applyStimulus(0, 1'b0, 32'd16, 32'd0, 3'b010);
      tick();
      checkOutput("rst_store_dropped", p0_rdata, 32'd0);
      clearRequests();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32i_dmem_arbiter.md
# rv32i_dmem_arbiter

Two-port arbiter and sequencer in front of `rv32i_data_mem`. It shares the single data memory between the pipeline MEM stage (port 0) and the debug/program-loader port (port 1). Port 0 normally has priority, and an anti-starvation counter guarantees port 1 progress. It returns registered read data with a valid strobe one cycle after grant, and it optionally rejects misaligned accesses before they reach memory.

## Interface
Parameters:
- `WIDTH`, 32, data width
- `ADDR_WIDTH`, 32, address width
- `STARVE_LIMIT`, 4, consecutive denied cycles of port 1 before it is forced a grant (1..15)

Ports (`X` = 0 or 1; `i_pX_*` / `o_pX_*` exist for both ports):
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_pX_req`  in  1  access request, held until `o_pX_gnt`
- `i_pX_we`  in  1  1 = store, 0 = load
- `i_pX_addr`  in  ADDR_WIDTH  byte address
- `i_pX_wdata`  in  WIDTH  store data
- `i_pX_func3`  in  3  RV32 load/store funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010)
- `o_pX_gnt`  out  1  combinational; request accepted this cycle
- `o_pX_rvalid`  out  1  registered; response for the last grant
- `o_pX_rdata`  out  WIDTH  registered load data; 0 for stores
- `o_pX_err`  out  1  registered; misaligned access rejected, qualified by `o_pX_rvalid`
- `o_dm_we`, `o_dm_addr`, `o_dm_data_in`, `o_dm_func3`  out  1/ADDR_WIDTH/WIDTH/3  drive `rv32i_data_mem`
- `i_dm_data_out`  in  WIDTH  memory read data (combinational read)

## Operation
- Arbitration runs every cycle. At most one grant per cycle.
  - Only one port requesting: that port wins.
  - Both requesting: port 0 wins unless `starve_cnt == STARVE_LIMIT`, in which case port 1 wins.
- `starve_cnt` (4 bits):
  - Increments when port 1 requests and is not granted.
  - Resets to 0 when port 1 is granted or `i_p1_req` = 0.
  - Saturates at `STARVE_LIMIT`.
- Winner's `we/addr/wdata/func3` are muxed combinationally onto `o_dm_*`.
- When there is no grant: `o_dm_we` = 0, other `o_dm_*` hold port 0's values (don't-care).
- At the grant edge:
  - The memory performs the store.
  - The response register captures `i_dm_data_out` for loads, 0 for stores.
- Response FSM states: `IDLE`, `RESP0`, `RESP1`.
  - Grant to port X → `RESPX` next cycle. No grant → `IDLE`.
  - Back-to-back grants are allowed: a new grant in `RESPX` goes to the new winner's state.
- `o_pX_rvalid` = 1 only in `RESPX`, for exactly one cycle per grant.
- Loads of a location stored in the immediately preceding cycle return the new data, since the memory write completes at the earlier edge.

## Timing
- Grant latency: 0 cycles, combinational from `req`.
- Response latency: 1 cycle; rvalid/rdata/err appear in the cycle after the grant.
- Throughput: one access per cycle total, across both ports.
- Requesters must keep `req` and payload stable until `gnt`. Dropping `req` before `gnt` is legal; no access occurs.
- Reset (`rst_n` = 0, asynchronous):
  - FSM → `IDLE`, `starve_cnt` = 0.
  - All `o_pX_rvalid`, `o_pX_err`, `o_pX_rdata` → 0.
  - `o_dm_we` forced 0.
  - Any in-flight response is discarded. A store granted in the same cycle reset asserts is not guaranteed.
- Reset release: arbitration resumes on the first rising edge with `rst_n` = 1.

## Configuration
- `DMEM_ARB_MISALIGN_CHK_EN` defined:
  - A granted access is misaligned if `func3[1:0]`=10 with `addr[1:0]`≠0, or `func3[1:0]`=01 with `addr[0]`=1.
  - Misaligned accesses still consume the grant, but `o_dm_we` is forced 0.
  - The next cycle gives `rvalid`=1, `err`=1, `rdata`=0.
- Not defined: no check. `o_pX_err` is tied 0 and all accesses go to memory unchanged.

## Test plan
- Port 0 SW `0xDEADBEEF` @0, then LW @0 → `o_p0_gnt` same cycle as req; next cycle `o_p0_rvalid`=1, `o_p0_rdata`=`0xDEADBEEF`.
- Port 1 alone: SB `0xDEADBEEF` @8, then LBU @8 → `o_p1_rdata`=`0x000000EF`; LB after SB `0x80` → `0xFFFFFF80`.
- Both ports request continuously, `STARVE_LIMIT`=4 → port 1 granted exactly once every 5 cycles; `starve_cnt` returns to 0 after its grant.
- Back-to-back port 0 SW @12 = `0xFFFFFFFB`, then LH @12 next cycle → rdata `0xFFFFFFFB`, rvalid high in two consecutive cycles.
- With `DMEM_ARB_MISALIGN_CHK_EN`: port 0 SW @2 → no memory write (`o_dm_we`=0); next cycle `err`=1, `rvalid`=1; a later LW @0 returns the old contents. Without the macro, the same SW reaches memory with `err`=0.
- Assert `rst_n`=0 mid-stream on a cycle between edges → `o_pX_rvalid`, `o_pX_err`, and `o_dm_we` drop to 0 immediately (asynchronous); after release, the first request is granted normally.
